// File: rtl/seq_shift_add_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier_if
// Description : Start/busy/done handshake bundle for the shift-and-add
//               multiplier.
// Revision    : 1.0
// ============================================================================
interface seq_shift_add_multiplier_if #(
    parameter int A_WIDTH = 4,
    parameter int B_WIDTH = 4
);
    logic                       start;
    logic                       is_signed;
    logic [A_WIDTH-1:0]         a;
    logic [B_WIDTH-1:0]         b;
    logic                       busy;
    logic                       done;
    logic [A_WIDTH+B_WIDTH-1:0] product;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier
// Description : Sequential shift-and-add multiplier, parametrised widths,
//               per-operation signed/unsigned mode, start/busy/done handshake.
// Revision    : 1.0
// ============================================================================
module seq_shift_add_multiplier #(
    parameter int A_WIDTH = 4,
    parameter int B_WIDTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    seq_shift_add_multiplier_if.slave bus
);
    localparam int CNT_W = $clog2(B_WIDTH);
    localparam int P_W   = A_WIDTH + B_WIDTH;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(B_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [A_WIDTH-1:0] r_ma;
    logic [B_WIDTH-1:0] r_mb;
    logic [A_WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;
    logic [P_W-1:0]     r_product;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [A_WIDTH-1:0] w_a_mag;
    logic [B_WIDTH-1:0] w_b_mag;
    logic [A_WIDTH:0]   w_sum;
    logic [P_W-1:0]     w_full;
    logic [P_W-1:0]     w_product;

    // Most negative input negates to itself, which read unsigned is its magnitude.
    assign w_a_neg   = bus.is_signed & bus.a[A_WIDTH-1];
    assign w_b_neg   = bus.is_signed & bus.b[B_WIDTH-1];
    assign w_a_mag   = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag   = w_b_neg ? -bus.b : bus.b;

    assign w_sum     = {1'b0, r_acc} + {1'b0, (r_mb[0] ? r_ma : {A_WIDTH{1'b0}})};
    // Multiplier bits have been shifted out; r_mb now holds the product LSBs.
    assign w_full    = {r_acc, r_mb};
    assign w_product = r_neg ? -w_full : w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (r_count == c_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ma      <= '0;
            r_mb      <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ma    <= w_a_mag;
                        r_mb    <= w_b_mag;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_sum[A_WIDTH:1];
                    r_mb    <= {w_sum[0], r_mb[B_WIDTH-1:1]};
                    r_count <= r_count + CNT_W'(1);
                end
                S_FIX: begin
                    r_product <= w_product;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shift_add_multiplier
// Description : Scoreboard bench for a 4x4 and an 8x6 multiplier instance.
// Revision    : 1.0
// ============================================================================
module tb_seq_shift_add_multiplier;
    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q86[$];

    seq_shift_add_multiplier_if #(.A_WIDTH(4), .B_WIDTH(4)) if4 ();
    seq_shift_add_multiplier_if #(.A_WIDTH(8), .B_WIDTH(6)) if86 ();

    seq_shift_add_multiplier #(.A_WIDTH(4), .B_WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    seq_shift_add_multiplier #(.A_WIDTH(8), .B_WIDTH(6)) u_dut86 (
        .clk (clk),
        .rst (rst),
        .bus (if86.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference product from plain integer arithmetic on sign-extended operands.
    function automatic logic [15:0] model(input int aw, input int bw, input bit sgn,
                                          input int av, input int bv);
        longint x = av;
        longint y = bv;
        longint p;
        if (sgn && av[aw-1]) x = av - (longint'(1) << aw);
        if (sgn && bv[bw-1]) y = bv - (longint'(1) << bw);
        p = x * y;
        return 16'(p & ((longint'(1) << (aw + bw)) - 1));
    endfunction

    task automatic issue(input bit big, input bit sgn, input int av, input int bv, input bit push);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        while ((big ? if86.busy : if4.busy) && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) check("busy_timeout", 64'(guard), 64'd0);
        if (big) begin
            if86.start = 1'b1; if86.is_signed = sgn; if86.a = 8'(av); if86.b = 6'(bv);
            e.prod = model(8, 6, sgn, av, bv);
            e.cyc  = cyc + 8;
            if (push) q86.push_back(e);
        end else begin
            if4.start = 1'b1; if4.is_signed = sgn; if4.a = 4'(av); if4.b = 4'(bv);
            e.prod = model(4, 4, sgn, av, bv);
            e.cyc  = cyc + 6;
            if (push) q4.push_back(e);
        end
        @(negedge clk);
        if4.start  = 1'b0;
        if86.start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q4.size() != 0 || q86.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("drain_timeout", 64'(q4.size() + q86.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if4.done === 1'b1) begin
            if (q4.size() == 0) begin
                check("done4_unexpected", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                check("prod4", 64'(if4.product), 64'(e.prod[7:0]));
                check("lat4", 64'(cyc), 64'(e.cyc));
            end
        end
        if (if86.done === 1'b1) begin
            if (q86.size() == 0) begin
                check("done86_unexpected", 64'd1, 64'd0);
            end else begin
                e = q86.pop_front();
                check("prod86", 64'(if86.product), 64'(e.prod[13:0]));
                check("lat86", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        exp_t e;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        if4.start = 1'b0;  if4.is_signed = 1'b0;  if4.a = '0;  if4.b = '0;
        if86.start = 1'b0; if86.is_signed = 1'b0; if86.a = '0; if86.b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy4", 64'(if4.busy), 64'd0);
        check("rst_done4", 64'(if4.done), 64'd0);
        check("rst_prod4", 64'(if4.product), 64'd0);
        check("rst_busy86", 64'(if86.busy), 64'd0);
        check("rst_done86", 64'(if86.done), 64'd0);
        check("rst_prod86", 64'(if86.product), 64'd0);
        rst = 1'b0;

        // Exhaustive unsigned 4x4
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                issue(1'b0, 1'b0, i, j, 1'b1);
        drain();

        // Signed 4x4 corners
        issue(1'b0, 1'b1, 8, 8, 1'b1);
        issue(1'b0, 1'b1, 8, 7, 1'b1);
        issue(1'b0, 1'b1, 15, 15, 1'b1);
        issue(1'b0, 1'b1, 7, 15, 1'b1);
        issue(1'b0, 1'b1, 0, 8, 1'b1);
        drain();

        // 8x6 instance, unsigned and signed extremes
        issue(1'b1, 1'b0, 255, 63, 1'b1);
        issue(1'b1, 1'b1, 128, 32, 1'b1);
        issue(1'b1, 1'b1, 127, 31, 1'b1);
        drain();

        // Start pulses while busy must not disturb the running 2*3
        issue(1'b0, 1'b0, 2, 3, 1'b1);
        repeat (3) begin
            @(negedge clk);
            if4.start = 1'b1; if4.a = 4'd15; if4.b = 4'd15;
        end
        @(negedge clk);
        if4.start = 1'b0;
        drain();
        check("hold_prod4", 64'(if4.product), 64'h06);

        // Abandon 9*9 with an async reset in its second RUN cycle
        issue(1'b0, 1'b0, 9, 9, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(if4.busy), 64'd0);
        check("arst_done", 64'(if4.done), 64'd0);
        check("arst_prod", 64'(if4.product), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 1'b0, 3, 5, 1'b1);
        drain();

        // Start held high: back-to-back ops six cycles apart
        @(negedge clk);
        if4.start = 1'b1; if4.is_signed = 1'b0; if4.a = 4'd6; if4.b = 4'd7;
        e.prod = 16'h002A; e.cyc = cyc + 6;
        q4.push_back(e);
        @(negedge clk);
        if4.a = 4'd3; if4.b = 4'd5;
        e.prod = 16'h000F; e.cyc = e.cyc + 6;
        q4.push_back(e);
        repeat (6) @(negedge clk);
        if4.start = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
